uart_tx_ctrl: RTL and testbench

UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

---
 rtl/uart_tx_ctrl.sv | 94 +++++++++
 tb/tb_uart_tx_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serialises a latched parallel word as start, data (LSB first),
// optional parity and stop bits, one bit per CLK cycle.
module uart_tx_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic [WIDTH-1:0] P_DATA,
    input  logic             Data_Valid,
    input  logic             PAR_EN,
    input  logic             parity,
    output logic             TX_OUT,
    output logic             Busy
);

    localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             par_en_q, par_en_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= StIdle;
            data_q   <= '0;
            par_en_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            par_en_q <= par_en_d;
            cnt_q    <= cnt_d;
        end
    end

    // Outputs are a pure decode of registered state, except the parity slot which
    // forwards the external parity calculator that is held stable during the frame.
    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        par_en_d = par_en_q;
        cnt_d    = cnt_q;
        TX_OUT   = 1'b1;
        Busy     = 1'b1;

        unique case (state_q)
            StIdle: begin
                Busy = 1'b0;
                if (Data_Valid) begin
                    data_d   = P_DATA;
                    par_en_d = PAR_EN;
                    cnt_d    = '0;
                    state_d  = StStart;
                end
            end
            StStart: begin
                TX_OUT  = 1'b0;
                state_d = StData;
            end
            StData: begin
                TX_OUT = data_q[cnt_q];
                // Hold the counter on the last bit so it never wraps inside DATA.
                if (cnt_q == CNT_LAST) begin
                    state_d = par_en_q ? StParity : StStop;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StParity: begin
                TX_OUT  = parity;
                state_d = StStop;
            end
            StStop: begin
                TX_OUT  = 1'b1;
                state_d = StIdle;
            end
            default: begin
                Busy    = 1'b0;
                state_d = StIdle;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Randomised and directed bench for uart_tx_ctrl; expected line activity comes from a
// frame-level queue model of {Busy, TX_OUT} per cycle.
module tb_uart_tx_ctrl;

    logic       CLK = 1'b0;
    logic       RST;
    logic [7:0] P_DATA;
    logic       Data_Valid, PAR_EN, parity, TX_OUT, Busy;
    logic [4:0] p_data5;
    logic       dv5, pe5, parity5, tx5, busy5;

    always #5 CLK = ~CLK;

    uart_tx_ctrl #(.WIDTH(8)) dut (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (P_DATA),
        .Data_Valid (Data_Valid),
        .PAR_EN     (PAR_EN),
        .parity     (parity),
        .TX_OUT     (TX_OUT),
        .Busy       (Busy)
    );

    uart_tx_ctrl #(.WIDTH(5)) dut5 (
        .CLK        (CLK),
        .RST        (RST),
        .P_DATA     (p_data5),
        .Data_Valid (dv5),
        .PAR_EN     (pe5),
        .parity     (parity5),
        .TX_OUT     (tx5),
        .Busy       (busy5)
    );

    int         n_tests = 0;
    int         n_fail  = 0;
    logic [1:0] exp_q[$];   // {busy, tx} for each remaining cycle of the current frame
    bit         rand_par = 1'b0;
    logic       obs_tx, obs_busy, obs_tx5, obs_busy5;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [1:0] exp_now();
        return (exp_q.size() != 0) ? exp_q[0] : 2'b01;
    endfunction

    // One clock cycle: drive, let the edge happen, advance the model, sample mid-cycle.
    task automatic cycle(input logic rst_v, input logic dv_v, input logic [7:0] d_v,
                         input logic pe_v);
        logic [1:0] e;
        RST        = rst_v;
        Data_Valid = dv_v;
        P_DATA     = d_v;
        PAR_EN     = pe_v;
        if (rand_par && exp_q.size() == 0) parity = 1'($urandom);
        @(posedge CLK);
        if (rst_v) begin
            exp_q.delete();
        end else if (exp_q.size() != 0) begin
            void'(exp_q.pop_front());
        end else if (dv_v) begin
            exp_q.push_back(2'b10);
            for (int i = 0; i < 8; i++) exp_q.push_back({1'b1, d_v[i]});
            if (pe_v) exp_q.push_back({1'b1, parity});
            exp_q.push_back(2'b11);
        end
        @(negedge CLK);
        obs_tx    = TX_OUT;
        obs_busy  = Busy;
        obs_tx5   = tx5;
        obs_busy5 = busy5;
        e = exp_now();
        check("tx", 32'(obs_tx), 32'(e[0]));
        check("busy", 32'(obs_busy), 32'(e[1]));
    endtask

    // Accept one word, then collect n line bits and count Busy over n+1 cycles.
    task automatic run_frame(input logic [7:0] d, input logic pe, input int n,
                             output logic [31:0] seq, output int nbusy);
        seq   = '0;
        nbusy = 0;
        for (int i = 0; i <= n; i++) begin
            cycle(1'b0, i == 0, d, pe);
            if (i < n) seq = {seq[30:0], obs_tx};
            nbusy += int'(obs_busy);
        end
    endtask

    initial begin
        logic [31:0] seq;
        int          nb;

        parity  = 1'b0;
        dv5     = 1'b0;
        p_data5 = '0;
        pe5     = 1'b0;
        parity5 = 1'b0;

        cycle(1'b1, 1'b0, 8'h00, 1'b0);
        cycle(1'b1, 1'b1, 8'hFF, 1'b1);
        check("rst_tx5", 32'(obs_tx5), 32'd1);
        check("rst_busy5", 32'(obs_busy5), 32'd0);

        // 0xA5 with parity 0, accepted on the first edge after reset release
        run_frame(8'hA5, 1'b1, 11, seq, nb);
        check("a5_seq", seq, 32'b01010010101);
        check("a5_busy", 32'(nb), 32'd11);

        run_frame(8'h01, 1'b0, 10, seq, nb);
        check("01_seq", seq, 32'b0100000001);
        check("01_busy", 32'(nb), 32'd10);

        // Mid-frame changes and a re-pulsed Data_Valid must not disturb 0x3C
        parity = 1'b1;
        cycle(1'b0, 1'b1, 8'h3C, 1'b1);
        repeat (3) cycle(1'b0, 1'b0, 8'h3C, 1'b1);
        repeat (2) cycle(1'b0, 1'b1, 8'hFF, 1'b0);
        repeat (6) cycle(1'b0, 1'b0, 8'hFF, 1'b0);
        check("3c_idle_busy", 32'(obs_busy), 32'd0);
        cycle(1'b0, 1'b0, 8'hFF, 1'b0);

        // Data_Valid held high: 0x55 then 0xAA, one idle cycle between frames
        seq = '0;
        for (int i = 0; i < 21; i++) begin
            cycle(1'b0, 1'b1, (i == 0) ? 8'h55 : 8'hAA, 1'b0);
            seq = {seq[30:0], obs_tx};
            if (i == 10) check("b2b_gap_busy", 32'(obs_busy), 32'd0);
        end
        check("b2b_seq", seq, 32'b010101010110010101011);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Reset during the 4th data bit of 0xF0 aborts the frame
        cycle(1'b0, 1'b1, 8'hF0, 1'b0);
        repeat (4) cycle(1'b0, 1'b0, 8'hF0, 1'b0);
        cycle(1'b1, 1'b0, 8'hF0, 1'b0);
        check("abort_tx", 32'(obs_tx), 32'd1);
        check("abort_busy", 32'(obs_busy), 32'd0);
        run_frame(8'h0F, 1'b0, 10, seq, nb);
        check("0f_seq", seq, 32'b0111100001);
        check("0f_busy", 32'(nb), 32'd10);

        // 5-bit instance, 5'b10011 with parity 1
        p_data5 = 5'b10011;
        pe5     = 1'b1;
        parity5 = 1'b1;
        dv5     = 1'b1;
        seq     = '0;
        nb      = 0;
        for (int i = 0; i < 9; i++) begin
            cycle(1'b0, 1'b0, 8'h00, 1'b0);
            dv5 = 1'b0;
            if (i < 8) seq = {seq[30:0], obs_tx5};
            nb += int'(obs_busy5);
        end
        check("w5_seq", seq, 32'b01100111);
        check("w5_busy", 32'(nb), 32'd8);
        check("w5_idle_tx", 32'(obs_tx5), 32'd1);

        rand_par = 1'b1;
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 2) == 0),
                  8'($urandom), 1'($urandom));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
